// File: rtl/simple_proc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : simple_proc_pkg
// Purpose  : Shared types and constants for the simpleProcessor multi-cycle
//            control unit: state enum, opcode/funct codes, ALU op encoding,
//            datapath select codes and the state -> control-word decode.
// Revision : 1.0  initial release
// ============================================================================
package simple_proc_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC_R = 4'd3,
    S_WB_R   = 4'd4,
    S_ADDR   = 4'd5,
    S_MEM_RD = 4'd6,
    S_MEM_WR = 4'd7,
    S_WB_LW  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_TRAP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_t;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;  // PC + 4 straight from the ALU
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;  // branch target held in ALUOut
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;  // jump target

  localparam logic [1:0] SRCB_RT      = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    alu_op_t    alu_op;
    logic       instr_done;
    logic       illegal;
  } ctrl_t;

  // Control word for a given state. mem_last marks the final cycle of a
  // data-memory access; r_op is the funct-derived ALU op for EXEC_R.
  function automatic ctrl_t ctrl_for_state(state_t st, logic mem_last, alu_op_t r_op);
    ctrl_t c;
    c = '0;
    case (st)
      S_FETCH: begin
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
        c.pc_src    = PCSRC_ALU;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALU_ADD;
      end
      S_DECODE: begin
        // Branch target is precomputed here whatever the instruction is.
        c.alu_src_b = SRCB_IMM_SH2;
        c.alu_op    = ALU_ADD;
      end
      S_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_RT;
        c.alu_op    = r_op;
      end
      S_WB_R: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = 1'b1;
        c.instr_done = 1'b1;
      end
      S_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ADD;
      end
      S_MEM_RD: c.mem_read = 1'b1;
      S_MEM_WR: begin
        c.mem_write  = 1'b1;
        c.instr_done = mem_last;
      end
      S_WB_LW: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.instr_done = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_RT;
        c.alu_op        = ALU_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_src        = PCSRC_ALUOUT;
        c.instr_done    = 1'b1;
      end
      S_JUMP: begin
        c.pc_write   = 1'b1;
        c.pc_src     = PCSRC_JUMP;
        c.instr_done = 1'b1;
      end
      S_TRAP:  c.illegal = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/simple_proc_alu_dec.sv
`default_nettype none
// ============================================================================
// Module   : simple_proc_alu_dec
// Purpose  : Combinational R-type funct decode to ALU op plus a legality flag
//            used by the controller to trap unsupported R-type encodings.
// Ports    : funct  [5:0] in  - IR[5:0]
//            alu_op [2:0] out - ALU operation (package encoding)
//            legal        out - 1 when funct is a supported R-type op
// Revision : 1.0  initial release
// ============================================================================
module simple_proc_alu_dec
  import simple_proc_pkg::*;
(
  input  logic [5:0] funct,
  output alu_op_t    alu_op,
  output logic       legal
);

  always_comb begin
    alu_op = ALU_ADD;
    legal  = 1'b1;
    case (funct)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_SLT:  alu_op = ALU_SLT;
      default: legal  = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/simple_proc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : simple_proc_ctrl
// Purpose  : Multi-cycle control unit for the simpleProcessor datapath.
//            Walks each instruction through FETCH/DECODE/EXEC/MEM/WB and
//            drives every datapath enable and select. Unsupported encodings
//            park the unit in TRAP until reset.
// Ports    : i_clk, i_rst_ (async, active low), i_run (level start/continue),
//            i_opcode/i_funct (IR fields), PC/IR/memory/regfile/ALU controls,
//            o_stepCount (cycle within instruction), o_instrDone, o_illegal.
// Revision : 1.0  initial release
// ============================================================================
module simple_proc_ctrl
  import simple_proc_pkg::*;
#(
  parameter int MEM_WAIT = 0,
  parameter int CNT_W    = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_,
  input  logic             i_run,
  input  logic [5:0]       i_opcode,
  input  logic [5:0]       i_funct,
  output logic             o_pcWrite,
  output logic             o_pcWriteCond,
  output logic [1:0]       o_pcSrc,
  output logic             o_irWrite,
  output logic             o_memRead,
  output logic             o_memWrite,
  output logic             o_regWrite,
  output logic             o_regDst,
  output logic             o_memToReg,
  output logic             o_aluSrcA,
  output logic [1:0]       o_aluSrcB,
  output logic [2:0]       o_aluOp,
  output logic [CNT_W-1:0] o_stepCount,
  output logic             o_instrDone,
  output logic             o_illegal
);

  localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

  state_t             state, state_nxt;
  logic [2:0]         wait_cnt, wait_nxt;
  logic [CNT_W-1:0]   step_cnt, step_nxt;
  ctrl_t              ctrl_q, ctrl_nxt;
  alu_op_t            dec_alu_op;
  logic               funct_legal;
  logic               mem_done;
  logic               mem_last_nxt;
  state_t             after_done;

  simple_proc_alu_dec u_alu_dec (
    .funct  (i_funct),
    .alu_op (dec_alu_op),
    .legal  (funct_legal)
  );

  always_comb begin
    mem_done   = (wait_cnt == WAIT_LAST);
    after_done = i_run ? S_FETCH : S_IDLE;
    state_nxt  = state;

    case (state)
      S_IDLE:   if (i_run) state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        case (i_opcode)
          OP_RTYPE:     state_nxt = funct_legal ? S_EXEC_R : S_TRAP;
          OP_LW, OP_SW: state_nxt = S_ADDR;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_J:         state_nxt = S_JUMP;
          default:      state_nxt = S_TRAP;
        endcase
      end
      S_EXEC_R: state_nxt = S_WB_R;
      S_ADDR:   state_nxt = (i_opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: if (mem_done) state_nxt = S_WB_LW;
      S_MEM_WR: if (mem_done) state_nxt = after_done;
      S_WB_R, S_WB_LW, S_BRANCH, S_JUMP: state_nxt = after_done;
      S_TRAP:   state_nxt = S_TRAP;
      default:  state_nxt = S_IDLE;
    endcase

    // Wait counter only advances while staying in the same memory state.
    if ((state_nxt == S_MEM_RD || state_nxt == S_MEM_WR) && state_nxt == state)
      wait_nxt = wait_cnt + 3'd1;
    else
      wait_nxt = 3'd0;
    mem_last_nxt = (wait_nxt == WAIT_LAST);

    if (state_nxt == S_FETCH || state_nxt == S_IDLE)
      step_nxt = '0;
    else if (state_nxt == S_TRAP || (&step_cnt))
      step_nxt = step_cnt;
    else
      step_nxt = step_cnt + CNT_W'(1);

    // Controls are decoded from the next state and registered, so each
    // output is a flop: same timing as decoding the state register, but
    // free of decode glitches and cleared directly by the async reset.
    ctrl_nxt = ctrl_for_state(state_nxt, mem_last_nxt, dec_alu_op);
  end

  always_ff @(posedge i_clk or negedge i_rst_) begin
    if (!i_rst_) begin
      state    <= S_IDLE;
      wait_cnt <= 3'd0;
      step_cnt <= '0;
      ctrl_q   <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      step_cnt <= step_nxt;
      ctrl_q   <= ctrl_nxt;
    end
  end

  assign o_pcWrite     = ctrl_q.pc_write;
  assign o_pcWriteCond = ctrl_q.pc_write_cond;
  assign o_pcSrc       = ctrl_q.pc_src;
  assign o_irWrite     = ctrl_q.ir_write;
  assign o_memRead     = ctrl_q.mem_read;
  assign o_memWrite    = ctrl_q.mem_write;
  assign o_regWrite    = ctrl_q.reg_write;
  assign o_regDst      = ctrl_q.reg_dst;
  assign o_memToReg    = ctrl_q.mem_to_reg;
  assign o_aluSrcA     = ctrl_q.alu_src_a;
  assign o_aluSrcB     = ctrl_q.alu_src_b;
  assign o_aluOp       = ctrl_q.alu_op;
  assign o_instrDone   = ctrl_q.instr_done;
  assign o_illegal     = ctrl_q.illegal;
  assign o_stepCount   = step_cnt;

endmodule
`default_nettype wire
